// File: rtl/preamble_detect_ctrl.sv
// Preamble detection sequencer: quiet-channel arming, peak-hold search over the
// banked correlator scores, single detection report, release/timeout hold-off and flush.
module preamble_detect_ctrl #(
  parameter int BANKS         = 16,
  parameter int CORR_WIDTH    = 7,
  parameter int THRESHOLD     = 58,
  parameter int PEAK_WINDOW   = 8,
  parameter int QUIET_SAMPLES = 4,
  parameter int HOLD_CYCLES   = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable_i,
  input  logic [CORR_WIDTH*BANKS-1:0]   corr_dat_i,
  input  logic                          corr_vld_i,
  input  logic                          all_zeros_i,
  input  logic                          release_i,
  output logic                          det_vld_o,
  output logic [$clog2(BANKS)-1:0]      det_bank_o,
  output logic [CORR_WIDTH-1:0]         det_score_o,
  output logic                          busy_o,
  output logic                          corr_rst_o
);

  localparam int BW = $clog2(BANKS);
  localparam int QW = $clog2(QUIET_SAMPLES + 1);
  localparam int WW = $clog2(PEAK_WINDOW + 1);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [QW-1:0]         QUIET_MAX = QW'(QUIET_SAMPLES);
  localparam logic [WW-1:0]         WIN_MAX   = WW'(PEAK_WINDOW);
  localparam logic [HW-1:0]         HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [CORR_WIDTH-1:0] THRESH    = CORR_WIDTH'(THRESHOLD);

  typedef enum logic [2:0] {IDLE, ARMED, PEAK, LOCKED, FLUSH} state_t;

  state_t                  state_q;
  logic [QW-1:0]           quiet_cnt_q;
  logic [WW-1:0]           win_cnt_q;
  logic [HW-1:0]           hold_cnt_q;
  logic [CORR_WIDTH-1:0]   pk_score_q;
  logic [BW-1:0]           pk_bank_q;
  logic                    det_vld_q;
  logic [BW-1:0]           det_bank_q;
  logic [CORR_WIDTH-1:0]   det_score_q;
  logic                    busy_q;
  logic                    corr_rst_q;

  logic [CORR_WIDTH-1:0]   bank_score [BANKS];
  logic [CORR_WIDTH-1:0]   best_score;
  logic [BW-1:0]           best_bank;
  logic [QW-1:0]           quiet_cnt_d;
  logic [WW-1:0]           win_cnt_d;

  generate
    for (genvar gi = 0; gi < BANKS; gi++) begin : g_unpack
      assign bank_score[gi] = corr_dat_i[gi*CORR_WIDTH +: CORR_WIDTH];
    end
  endgenerate

  // Strict compare while scanning upward keeps the lowest index on ties.
  always_comb begin
    best_score = bank_score[0];
    best_bank  = '0;
    for (int i = 1; i < BANKS; i++) begin
      if (bank_score[i] > best_score) begin
        best_score = bank_score[i];
        best_bank  = BW'(i);
      end
    end
  end

  always_comb begin
    quiet_cnt_d = '0;
    if (all_zeros_i) begin
      quiet_cnt_d = (quiet_cnt_q == QUIET_MAX) ? quiet_cnt_q : quiet_cnt_q + QW'(1);
    end
    win_cnt_d = win_cnt_q + WW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      quiet_cnt_q <= '0;
      win_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      pk_score_q  <= '0;
      pk_bank_q   <= '0;
      det_vld_q   <= 1'b0;
      det_bank_q  <= '0;
      det_score_q <= '0;
      busy_q      <= 1'b0;
      corr_rst_q  <= 1'b0;
    end else begin
      det_vld_q  <= 1'b0;
      corr_rst_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (quiet_cnt_q == QUIET_MAX && enable_i) begin
            state_q     <= ARMED;
            quiet_cnt_q <= '0;
          end else if (corr_vld_i) begin
            quiet_cnt_q <= quiet_cnt_d;
          end
        end
        ARMED: begin
          if (!enable_i) begin
            state_q <= IDLE;
          end else if (corr_vld_i && best_score >= THRESH) begin
            state_q    <= PEAK;
            pk_score_q <= best_score;
            pk_bank_q  <= best_bank;
            win_cnt_q  <= '0;
            busy_q     <= 1'b1;
          end
        end
        PEAK: begin
          if (!enable_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (corr_vld_i) begin
            if (best_score > pk_score_q) begin
              pk_score_q <= best_score;
              pk_bank_q  <= best_bank;
              win_cnt_q  <= '0;
            end else if (win_cnt_d == WIN_MAX) begin
              state_q     <= LOCKED;
              det_vld_q   <= 1'b1;
              det_bank_q  <= pk_bank_q;
              det_score_q <= pk_score_q;
              hold_cnt_q  <= '0;
            end else begin
              win_cnt_q <= win_cnt_d;
            end
          end
        end
        LOCKED: begin
          if (release_i || hold_cnt_q == HOLD_LAST) begin
            state_q    <= FLUSH;
            corr_rst_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q + HW'(1);
          end
        end
        FLUSH: begin
          state_q     <= IDLE;
          quiet_cnt_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign det_vld_o   = det_vld_q;
  assign det_bank_o  = det_bank_q;
  assign det_score_o = det_score_q;
  assign busy_o      = busy_q;
  assign corr_rst_o  = corr_rst_q;

endmodule
